// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO sequencer.
package hilo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIV_GO,
        DIV_WAIT,
        MUL_GO,
        MUL_WAIT
    } hilo_state_t;

    localparam logic OP_DIV  = 1'b0;
    localparam logic OP_MULT = 1'b1;

    localparam int unsigned DEF_TIMEOUT = 40;

endpackage

// File: rtl/hilo_seq_if.sv
// Start/stop handshake and result buses between the sequencer and the div/mult units.
interface hilo_seq_if;

    logic        div_ctrl;
    logic        div_stop;
    logic        div_zero;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    logic        mult_ctrl;
    logic        mult_stop;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;

    modport master (
        output div_ctrl, mult_ctrl,
        input  div_stop, div_zero, div_hi, div_lo,
        input  mult_stop, mult_hi, mult_lo
    );

    modport slave (
        input  div_ctrl, mult_ctrl,
        output div_stop, div_zero, div_hi, div_lo,
        output mult_stop, mult_hi, mult_lo
    );

endinterface

// File: rtl/hilo_timer.sv
// Loadable up-counter; tc flags the last cycle of a TIMEOUT-cycle window.
module hilo_timer #(
    parameter int unsigned TW      = 6,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [TW-1:0] count;

    assign tc = (count == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/hilo_seq.sv
// DIV/MULT sequencer with architectural HI/LO registers, MTHI/MTLO writes and
// stop/zero/timeout handling towards the control unit.
module hilo_seq
    import hilo_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned TW      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic              op_sel,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [31:0]       wdata,
    hilo_seq_if.master        unit,
    output logic              unit_rst,
    output logic [31:0]       hi,
    output logic [31:0]       lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero_exc,
    output logic              timeout_err
);

    hilo_state_t state;
    logic        tc;

    assign busy = (state != IDLE);

    // Counter sits at 0 while idle, so it reads 0 in the GO cycle and counts WAIT cycles from there.
    hilo_timer #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (state == IDLE),
        .en    (busy),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            hi             <= '0;
            lo             <= '0;
            done           <= 1'b0;
            div_zero_exc   <= 1'b0;
            timeout_err    <= 1'b0;
            unit.div_ctrl  <= 1'b0;
            unit.mult_ctrl <= 1'b0;
            unit_rst       <= 1'b1;
        end else begin
            unit_rst       <= 1'b0;
            done           <= 1'b0;
            div_zero_exc   <= 1'b0;
            unit.div_ctrl  <= 1'b0;
            unit.mult_ctrl <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi_we) hi <= wdata;
                    if (mtlo_we) lo <= wdata;
                    if (op_start) begin
                        timeout_err <= 1'b0;
                        if (op_sel == OP_DIV) begin
                            state         <= DIV_GO;
                            unit.div_ctrl <= 1'b1;
                        end else begin
                            state          <= MUL_GO;
                            unit.mult_ctrl <= 1'b1;
                        end
                    end
                end
                DIV_GO: state <= DIV_WAIT;
                DIV_WAIT: begin
                    // Zero beats stop; either completion beats a coincident timeout.
                    if (unit.div_zero) begin
                        div_zero_exc <= 1'b1;
                        state        <= IDLE;
                    end else if (unit.div_stop) begin
                        hi    <= unit.div_hi;
                        lo    <= unit.div_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (tc) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                MUL_GO: state <= MUL_WAIT;
                MUL_WAIT: begin
                    if (unit.mult_stop) begin
                        hi    <= unit.mult_hi;
                        lo    <= unit.mult_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (tc) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
